// File: rtl/ct_fcnvt_pkg.sv
// Shared encodings and saturation constants for the float-to-integer convert path.
package ct_fcnvt_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        FT_W  = 2'b00,
        FT_WU = 2'b01,
        FT_L  = 2'b10,
        FT_LU = 2'b11
    } ftype_e;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    // 32-bit bounds are stored already sign-extended to XLEN.
    localparam logic [63:0] W_MAX  = 64'h0000_0000_7FFF_FFFF;
    localparam logic [63:0] W_MIN  = 64'hFFFF_FFFF_8000_0000;
    localparam logic [63:0] WU_MAX = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] L_MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] L_MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] LU_MAX = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] U_MIN  = 64'h0;

    function automatic logic [63:0] sat_max(input ftype_e t);
        case (t)
            FT_W:    sat_max = W_MAX;
            FT_WU:   sat_max = WU_MAX;
            FT_L:    sat_max = L_MAX;
            default: sat_max = LU_MAX;
        endcase
    endfunction

    function automatic logic [63:0] sat_min(input ftype_e t);
        case (t)
            FT_W:    sat_min = W_MIN;
            FT_L:    sat_min = L_MIN;
            default: sat_min = U_MIN;
        endcase
    endfunction

endpackage

// File: rtl/ct_fcnvt_ftoi_sat.sv
// Combinational saturation / sign application for the rounded magnitude.
// Zero latency; no flow control of its own.
module ct_fcnvt_ftoi_sat
    import ct_fcnvt_pkg::*;
(
    input  logic [64:0] mag_i,
    input  logic        sign_i,
    input  ftype_e      type_i,
    input  logic        nan_i,
    input  logic        inf_ovf_i,
    input  logic        inexact_i,
    output logic [63:0] result_o,
    output logic [4:0]  fflags_o
);

    logic        is32;
    logic        is_uns;
    logic [64:0] lim;
    logic [63:0] max_v;
    logic [63:0] min_v;
    logic [63:0] neg_mag;
    logic [63:0] res;
    logic        nv;
    logic        nx;

    always_comb begin
        is32    = (type_i == FT_W) || (type_i == FT_WU);
        is_uns  = type_i[0];
        max_v   = sat_max(type_i);
        min_v   = sat_min(type_i);
        neg_mag = ~mag_i[63:0] + 64'd1;
        lim     = is32 ? 65'h0_0000_0000_7FFF_FFFF : 65'h0_7FFF_FFFF_FFFF_FFFF;
        res     = '0;
        nv      = 1'b0;
        nx      = 1'b0;
        if (nan_i) begin
            res = max_v;
            nv  = 1'b1;
        end else if (inf_ovf_i) begin
            res = sign_i ? min_v : max_v;
            nv  = 1'b1;
        end else if (!is_uns) begin
            // Negative side reaches one further than the positive side.
            if (sign_i ? (mag_i > lim + 65'd1) : (mag_i > lim)) begin
                res = sign_i ? min_v : max_v;
                nv  = 1'b1;
            end else begin
                res = sign_i ? neg_mag : mag_i[63:0];
                nx  = inexact_i;
            end
        end else if (sign_i) begin
            res = '0;
            nv  = (mag_i != 65'd0);
            nx  = (mag_i == 65'd0) & inexact_i;
        end else if (is32 ? (mag_i[64:32] != 33'd0) : mag_i[64]) begin
            res = max_v;
            nv  = 1'b1;
        end else begin
            res = mag_i[63:0];
            nx  = inexact_i;
        end
        if (is32) begin
            res = {{32{res[31]}}, res[31:0]};
        end
        result_o        = res;
        fflags_o        = '0;
        fflags_o[FF_NV] = nv;
        fflags_o[FF_NX] = nx & ~nv;
    end

endmodule

// File: rtl/ct_fcnvt_ftoi_rnd.sv
// ftoi round (ex1->ex2) and saturate (ex2->ex3); 2-cycle latency.
// ex1_stall freezes every stage; rtu_flush kills both valids and beats stall and new input.
module ct_fcnvt_ftoi_rnd
    import ct_fcnvt_pkg::*;
(
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        ex1_vld,
    input  logic        ex1_stall,
    input  logic        rtu_flush,
    input  logic        ex1_sign,
    input  logic [2:0]  ex1_rm,
    input  logic [1:0]  ex1_type,
    input  logic        ex1_nan,
    input  logic        ex1_inf_ovf,
    input  logic [63:0] fsh_i_v_nm,
    input  logic [53:0] fsh_i_x_nm,
    output logic        ex3_vld,
    output logic [63:0] ex3_result,
    output logic [4:0]  ex3_fflags
);

    logic        guard;
    logic        sticky;
    logic        inexact;
    logic        inc;
    logic [64:0] mag_d;

    logic        ex2_vld_q, ex2_vld_d;
    logic        ex2_sign_q;
    ftype_e      ex2_type_q;
    logic        ex2_nan_q;
    logic        ex2_inf_ovf_q;
    logic        ex2_inexact_q;
    logic [64:0] ex2_mag_q;

    logic        ex3_vld_q, ex3_vld_d;
    logic [63:0] ex3_result_q, ex3_result_d;
    logic [4:0]  ex3_fflags_q, ex3_fflags_d;

    always_comb begin
        guard   = fsh_i_x_nm[53];
        sticky  = |fsh_i_x_nm[52:0];
        inexact = guard | sticky;
        case (ex1_rm)
            RM_RNE:  inc = guard & (sticky | fsh_i_v_nm[0]);
            RM_RDN:  inc = ex1_sign & inexact;
            RM_RUP:  inc = ~ex1_sign & inexact;
            RM_RMM:  inc = guard;
            default: inc = 1'b0;
        endcase
        mag_d = {1'b0, fsh_i_v_nm} + {64'd0, inc};
    end

    always_comb begin
        ex2_vld_d = ex2_vld_q;
        ex3_vld_d = ex3_vld_q;
        if (rtu_flush) begin
            ex2_vld_d = 1'b0;
            ex3_vld_d = 1'b0;
        end else if (!ex1_stall) begin
            ex2_vld_d = ex1_vld;
            ex3_vld_d = ex2_vld_q;
        end
    end

    ct_fcnvt_ftoi_sat u_sat (
        .mag_i     (ex2_mag_q),
        .sign_i    (ex2_sign_q),
        .type_i    (ex2_type_q),
        .nan_i     (ex2_nan_q),
        .inf_ovf_i (ex2_inf_ovf_q),
        .inexact_i (ex2_inexact_q),
        .result_o  (ex3_result_d),
        .fflags_o  (ex3_fflags_d)
    );

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex2_vld_q <= 1'b0;
            ex3_vld_q <= 1'b0;
        end else begin
            ex2_vld_q <= ex2_vld_d;
            ex3_vld_q <= ex3_vld_d;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex2_sign_q    <= 1'b0;
            ex2_type_q    <= FT_W;
            ex2_nan_q     <= 1'b0;
            ex2_inf_ovf_q <= 1'b0;
            ex2_inexact_q <= 1'b0;
            ex2_mag_q     <= '0;
        end else if (ex1_vld && !ex1_stall) begin
            ex2_sign_q    <= ex1_sign;
            ex2_type_q    <= ftype_e'(ex1_type);
            ex2_nan_q     <= ex1_nan;
            ex2_inf_ovf_q <= ex1_inf_ovf;
            ex2_inexact_q <= inexact;
            ex2_mag_q     <= mag_d;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex3_result_q <= '0;
            ex3_fflags_q <= '0;
        end else if (ex2_vld_q && !ex1_stall) begin
            ex3_result_q <= ex3_result_d;
            ex3_fflags_q <= ex3_fflags_d;
        end
    end

    assign ex3_vld    = ex3_vld_q;
    assign ex3_result = ex3_result_q;
    assign ex3_fflags = ex3_fflags_q;

endmodule
